// File: rtl/data_sram_responder_if.sv
// Data SRAM request/response bus between the core (master) and its far-end responder (slave).
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [7:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Far end of the core's data port: byte-writable 64-bit memory plus an MMIO block
// holding a console TX FIFO, a free-running cycle counter and a sticky halt register.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  data_sram_responder_if.slave       bus,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic                       halt,
  output logic [7:0]                 halt_code,
  output logic                       bus_err
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned TAG_LSB   = ADDR_WIDTH + 3;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLE  = 2'd2;
  localparam logic [1:0] REG_HALT   = 2'd3;

  logic [63:0]            mem [MEM_DEPTH];
  logic [7:0]             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CNT_W-1:0]       fifo_cnt, cnt_next;
  logic [15:0]            drop_cnt;
  logic [63:0]            cycle;

  logic                   is_wr, mem_hit, mmio_hit, unmapped;
  logic [ADDR_WIDTH-1:0]  mem_idx;
  logic [1:0]             reg_sel;
  logic [63:0]            mmio_rd, rd_next_data;
  logic                   fifo_full, fifo_empty;
  logic                   push_req, push_ok, pop, drop, halt_wr;
  logic [7:0]             head_next;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^bus.data_sram_addr[2:0];

  // Address decode, qualified by the request strobe.
  assign is_wr    = |bus.data_sram_wen;
  assign mem_hit  = bus.data_sram_en && (bus.data_sram_addr[31:TAG_LSB] == MEM_BASE[31:TAG_LSB]);
  assign mmio_hit = bus.data_sram_en && (bus.data_sram_addr[31:5] == MMIO_BASE[31:5]);
  assign unmapped = bus.data_sram_en && !mem_hit && !mmio_hit;
  assign mem_idx  = bus.data_sram_addr[TAG_LSB-1:3];
  assign reg_sel  = bus.data_sram_addr[4:3];

  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign push_req = mmio_hit && (reg_sel == REG_TXDATA) && bus.data_sram_wen[0];
  assign pop      = tx_valid && tx_ready;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign drop     = push_req && !push_ok;
  assign halt_wr  = mmio_hit && (reg_sel == REG_HALT) && bus.data_sram_wen[0] && !halt;

  // MMIO read mux; all values reflect state before the sampling edge.
  always_comb begin
    mmio_rd = '0;
    unique case (reg_sel)
      REG_STATUS: mmio_rd = {32'b0, drop_cnt, 8'(fifo_cnt), 6'b0, fifo_empty, fifo_full};
      REG_CYCLE:  mmio_rd = cycle;
      REG_HALT:   mmio_rd = {55'b0, halt, halt_code};
      default:    mmio_rd = '0;
    endcase
  end

  always_comb begin
    rd_next_data = '0;
    if (mem_hit)       rd_next_data = mem[mem_idx];
    else if (mmio_hit) rd_next_data = mmio_rd;
  end

  // FIFO next state; the head is pre-computed so tx_data comes straight from a flop.
  always_comb begin
    rd_next  = pop     ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_next  = push_ok ? wr_ptr + PTR_W'(1) : wr_ptr;
    cnt_next = fifo_cnt;
    unique case ({push_ok, pop})
      2'b10:   cnt_next = fifo_cnt + CNT_W'(1);
      2'b01:   cnt_next = fifo_cnt - CNT_W'(1);
      default: cnt_next = fifo_cnt;
    endcase
    head_next = '0;
    if (cnt_next != '0) begin
      if (push_ok && (rd_next == wr_ptr)) head_next = bus.data_sram_wdata[7:0];
      else                                head_next = fifo_mem[rd_next];
    end
  end

  // Storage arrays carry no reset; accesses sampled during reset are dropped.
  always_ff @(posedge clock) begin
    if (!reset && mem_hit && is_wr) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.data_sram_wen[i]) mem[mem_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
    if (!reset && push_ok) fifo_mem[wr_ptr] <= bus.data_sram_wdata[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.data_sram_rdata <= '0;
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      fifo_cnt            <= '0;
      tx_valid            <= 1'b0;
      tx_data             <= '0;
      drop_cnt            <= '0;
      cycle               <= '0;
      halt                <= 1'b0;
      halt_code           <= '0;
      bus_err             <= 1'b0;
    end else begin
      cycle <= cycle + 64'd1;
      if (bus.data_sram_en) bus.data_sram_rdata <= rd_next_data;
      rd_ptr   <= rd_next;
      wr_ptr   <= wr_next;
      fifo_cnt <= cnt_next;
      tx_valid <= (cnt_next != '0);
      tx_data  <= head_next;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (halt_wr) begin
        halt      <= 1'b1;
        halt_code <= bus.data_sram_wdata[7:0];
      end
      if (unmapped) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: queued expectations checked by independent monitors.
module tb_data_sram_responder;
  localparam logic [31:0] A10   = 32'h8000_0010;
  localparam logic [31:0] A18   = 32'h8000_0018;
  localparam logic [31:0] TXD   = 32'h1000_0000;
  localparam logic [31:0] STAT  = 32'h1000_0008;
  localparam logic [31:0] CYC   = 32'h1000_0010;
  localparam logic [31:0] HLT   = 32'h1000_0018;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       halt;
  logic [7:0] halt_code;
  logic       bus_err;

  data_sram_responder_if bus ();

  data_sram_responder dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .halt      (halt),
    .halt_code (halt_code),
    .bus_err   (bus_err)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          hs_cnt = 0;
  logic [63:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic        drv_check = 1'b0;
  logic        chk_q = 1'b0;
  logic [63:0] model_cyc;
  logic [63:0] cyc_v;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request slot 2 time units after the edge; it is sampled on the next edge.
  task automatic slot(input logic en, input logic [7:0] wen, input logic [31:0] addr,
                      input logic [63:0] wdata, input logic chk, input logic [63:0] exp);
    @(posedge clock);
    #2;
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    drv_check = chk;
    if (chk) rd_q.push_back(exp);
  endtask

  task automatic idle();
    slot(1'b0, 8'h00, 32'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] wen, input logic [63:0] wdata,
                    input logic chk, input logic [63:0] exp_old);
    slot(1'b1, wen, addr, wdata, chk, exp_old);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [63:0] exp);
    slot(1'b1, 8'h00, addr, 64'h0, 1'b1, exp);
  endtask

  // CYCLE read whose expectation is the reference counter value at drive time.
  task automatic rd_cyc(output logic [63:0] v);
    @(posedge clock);
    #2;
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = 8'h00;
    bus.data_sram_addr  = CYC;
    bus.data_sram_wdata = 64'h0;
    drv_check = 1'b1;
    v = model_cyc;
    rd_q.push_back(v);
  endtask

  task automatic drain(input int expected_hs);
    for (int k = 0; k < 30 && tx_valid; k++) idle();
    cmp("tx_valid_drained", 64'(tx_valid), 64'd0);
    cmp("handshake_count", 64'(hs_cnt), 64'(expected_hs));
  endtask

  always @(posedge clock) begin
    chk_q     <= drv_check;
    model_cyc <= reset ? 64'd0 : model_cyc + 64'd1;
  end

  // Monitor: rdata one cycle after a checked request, tx bytes on every handshake.
  always @(negedge clock) begin
    if (chk_q) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected: got %h expected none", bus.data_sram_rdata);
      end else begin
        cmp("rdata", bus.data_sram_rdata, rd_q.pop_front());
      end
    end
    if (tx_valid && tx_ready) begin
      hs_cnt++;
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected: got %h expected none", tx_data);
      end else begin
        cmp("tx_data", 64'(tx_data), 64'(tx_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 8'h00;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 64'h0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    cmp("reset_rdata", bus.data_sram_rdata, 64'h0);
    cmp("reset_tx_valid", 64'(tx_valid), 64'd0);
    cmp("reset_tx_data", 64'(tx_data), 64'd0);
    cmp("reset_halt", 64'(halt), 64'd0);
    cmp("reset_halt_code", 64'(halt_code), 64'd0);
    cmp("reset_bus_err", 64'(bus_err), 64'd0);

    // Byte-lane merge and read-first behaviour.
    wr(A10, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0);
    wr(A10, 8'h03, 64'h0000_0000_0000_AAAA, 1'b1, 64'h1122_3344_5566_7788);
    rd(A10, 64'h1122_3344_5566_AAAA);
    wr(A18, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0);
    wr(A18, 8'h0F, 64'h0000_0000_CAFE_BABE, 1'b1, 64'hDEAD_BEEF_0000_0001);
    rd(A18, 64'hDEAD_BEEF_CAFE_BABE);

    // Overfill the FIFO, then drain it.
    for (int i = 0; i < 10; i++) begin
      wr(TXD, 8'h01, 64'(8'h41 + 8'(i)), (i < 2), 64'h0);
      if (i < 8) tx_q.push_back(8'h41 + 8'(i));
    end
    rd(STAT, 64'h0000_0000_0002_0801);
    hs_cnt = 0;
    tx_ready = 1'b1;
    drain(8);
    rd(STAT, 64'h0000_0000_0002_0002);

    // Push into a full FIFO in the same cycle as a pop.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(TXD, 8'h01, 64'(8'h51 + 8'(i)), 1'b0, 64'h0);
      tx_q.push_back(8'h51 + 8'(i));
    end
    hs_cnt = 0;
    wr(TXD, 8'h01, 64'h5A, 1'b0, 64'h0);
    tx_ready = 1'b1;
    tx_q.push_back(8'h5A);
    drain(9);
    rd(STAT, 64'h0000_0000_0002_0002);

    // Cycle counter, two reads five cycles apart.
    rd_cyc(cyc_v);
    repeat (4) idle();
    rd_cyc(cyc_v);

    // Reset mid-run with pending FIFO data and a memory write sampled during reset.
    tx_ready = 1'b0;
    wr(TXD, 8'h01, 64'h61, 1'b0, 64'h0);
    wr(TXD, 8'h01, 64'h62, 1'b0, 64'h0);
    idle();
    cmp("tx_valid_before_reset", 64'(tx_valid), 64'd1);
    reset = 1'b1;
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = 8'hFF;
    bus.data_sram_addr  = A10;
    bus.data_sram_wdata = 64'h0;
    drv_check = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    bus.data_sram_en  = 1'b0;
    bus.data_sram_wen = 8'h00;
    cmp("midreset_tx_valid", 64'(tx_valid), 64'd0);
    cmp("midreset_tx_data", 64'(tx_data), 64'd0);
    cmp("midreset_rdata", bus.data_sram_rdata, 64'h0);
    idle();
    idle();
    rd(CYC, 64'd3);
    rd(STAT, 64'h0000_0000_0000_0002);
    rd(A10, 64'h1122_3344_5566_AAAA);

    // Unmapped access and sticky halt.
    idle();
    cmp("bus_err_clear", 64'(bus_err), 64'd0);
    rd(32'h2000_0000, 64'h0);
    idle();
    cmp("bus_err_set", 64'(bus_err), 64'd1);
    wr(HLT, 8'h01, 64'h07, 1'b1, 64'h0);
    idle();
    cmp("halt_set", 64'(halt), 64'd1);
    cmp("halt_code_first", 64'(halt_code), 64'h07);
    wr(HLT, 8'h01, 64'h09, 1'b1, 64'h107);
    rd(HLT, 64'h107);
    idle();
    cmp("halt_code_kept", 64'(halt_code), 64'h07);

    repeat (2) idle();
    cmp("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    cmp("tx_queue_empty", 64'(tx_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Simulation-side responder for the core's data SRAM interface: it answers `data_sram_*` requests from the processor top with a byte-writable 64-bit memory and a small MMIO block. The MMIO block provides a console transmit FIFO, a free-running cycle counter and a halt register. It sits beside the core top in the difftest/trace harness and replaces the external memory model as the far end of the data port.

## Interface
- `ADDR_WIDTH`, 16, doubleword index bits; memory is 2^ADDR_WIDTH x 64 bit (512 KiB at default).
- `MEM_BASE`, 32'h8000_0000, memory base; must be aligned to 2^(ADDR_WIDTH+3).
- `MMIO_BASE`, 32'h1000_0000, MMIO base; 32-byte window.
- `FIFO_DEPTH`, 8, console FIFO entries; power of two, at least 2.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `data_sram_en`  in  1  request valid this cycle.
- `data_sram_wen`  in  8  byte write enables; zero means read.
- `data_sram_addr`  in  32  byte address; bits [2:0] are ignored.
- `data_sram_wdata`  in  64  write data, lane-aligned.
- `data_sram_rdata`  out  64  read data, registered.
- `tx_valid`  out  1  FIFO head valid.
- `tx_data`  out  8  FIFO head byte.
- `tx_ready`  in  1  sink accepts the head.
- `halt`  out  1  sticky halt flag.
- `halt_code`  out  8  code written with halt.
- `bus_err`  out  1  sticky; set by any access that hits no region.

## Operation
- Decode, qualified by `data_sram_en`:
  - mem hit when addr[31:ADDR_WIDTH+3] equals the same bits of MEM_BASE; index = addr[ADDR_WIDTH+2:3].
  - mmio hit when addr[31:5] equals MMIO_BASE[31:5]; reg = addr[4:3].
  - anything else is unmapped.
- Memory writes: byte lane i is written when wen[i] is set; other lanes are preserved. Memory contents are not reset.
- Memory reads return the whole doubleword; the core extracts lanes.
- MMIO registers:
  - reg 0 TXDATA, write only; reads return 0. A write with wen[0] pushes wdata[7:0].
  - reg 1 STATUS, read only:
    - [0] full
    - [1] empty
    - [15:8] occupancy
    - [31:16] drop count, saturating at 16'hFFFF
    - other bits 0
  - reg 2 CYCLE, read only: 64-bit counter, +1 every cycle, wraps to 0.
  - reg 3 HALT: a write with wen[0] sets `halt` and loads `halt_code`=wdata[7:0]. Later writes are ignored. Reads return {55'b0, halt, halt_code}.
- Writes to read-only registers are ignored.
- Unmapped accesses: reads return 64'h0, writes are discarded, `bus_err` is set.
- FIFO:
  - A push is accepted if occupancy < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and the drop count increments.
  - Pop occurs when `tx_valid && tx_ready`.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is held in $clog2(FIFO_DEPTH)+1 bits.
  - Bytes leave in write order.

## Timing
- Read latency is 1 cycle: rdata in cycle N+1 reflects the request sampled at edge N.
- With en=0, rdata holds its last value.
- A write request also updates rdata, with the pre-write contents (read-first). A read of the same address in N+1 sees the new data.
- A CYCLE read returns the counter value in the request cycle; STATUS likewise reflects pre-edge state.
- `tx_valid` is asserted the cycle after a push into an empty FIFO; there is no combinational path from push to `tx_valid`.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- Reset values:
  - rdata 0
  - FIFO empty (tx_valid 0, tx_data 0)
  - drop count 0, cycle 0
  - halt 0, halt_code 0, bus_err 0
- Reset mid-operation discards FIFO contents and pending rdata. Memory contents are retained.
- An access sampled in the same cycle as reset is ignored.
- Throughput: one request per cycle, with no back-pressure on the data port.

## Test plan
- Write 64'h1122334455667788 to 0x8000_0010 with wen=8'hFF, then write 64'hAAAA with wen=8'h03, then read: rdata = 64'h112233445566AAAA one cycle after the read.
- Write and read the same address in back-to-back cycles: the write cycle's rdata is the old value; the read returns the new value.
- Push 10 bytes 0x41..0x4A with tx_ready=0 (DEPTH 8): STATUS = full, occupancy 8, drop count 2. Then raise tx_ready: 0x41..0x48 drain in order and tx_valid drops after 8 handshakes.
- With the FIFO full and tx_ready=1, push 0x5A in the pop cycle: the push is accepted, drop count is unchanged, and 0x5A is eventually emitted.
- Read CYCLE twice, 5 cycles apart: the difference is 5. Assert reset mid-run: the next CYCLE read returns the cycles elapsed since reset deasserted.
- Read 0x2000_0000: rdata 0 and bus_err=1. Write 0x07 to HALT: halt=1, halt_code=0x07; a second HALT write of 0x09 leaves halt_code=0x07.
